// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - loads a byte-streamed program into instruction memory, then releases the core.
// Optional trailing checksum check enabled by defining BOOT_CHECKSUM_EN.
module imem_boot_loader #(
    parameter int MEM_WORDS = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    input  logic [31:0]       pc,
    output logic [31:0]       imem_addr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              boot_done,
    output logic              boot_err
);

    typedef enum logic [2:0] {
        S_HDR0 = 3'd0,
        S_HDR1 = 3'd1,
        S_DATA = 3'd2,
        S_RUN  = 3'd3,
        S_ERR  = 3'd4
`ifdef BOOT_CHECKSUM_EN
        ,
        S_CSUM = 3'd5
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [23:0]       acc_q, acc_d;
    logic              s_ready_q, s_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0]       csum_q, csum_d;
`endif

    logic        xfer;
    logic [31:0] word_full;
    logic [15:0] n_new;
    logic        last_word;

    // Only the three lower bytes need storing; the fourth arrives with the handshake that completes the word.
    function automatic logic [23:0] place_byte(input logic [23:0] acc, input logic [1:0] k,
                                               input logic [7:0] b);
        logic [23:0] r;
        r = acc;
        case (k)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            default: r[23:16] = b;
        endcase
        return r;
    endfunction

    assign xfer      = s_valid && s_ready_q;
    assign word_full = {s_data, acc_q};
    assign n_new     = {s_data, n_q[7:0]};
    assign last_word = (16'(word_cnt_q) == (n_q - 16'd1));

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        byte_cnt_d  = byte_cnt_q;
        word_cnt_d  = word_cnt_q;
        acc_d       = acc_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef BOOT_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            S_HDR0: begin
                if (xfer) begin
                    n_d[7:0] = s_data;
                    state_d  = S_HDR1;
                end
            end
            S_HDR1: begin
                if (xfer) begin
                    n_d = n_new;
                    if (n_new == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_RUN;
`endif
                    end else if (n_new > 16'(MEM_WORDS)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_waddr_d = word_cnt_q;
                        mem_wdata_d = word_full;
                        word_cnt_d  = word_cnt_q + ADDR_W'(1);
`ifdef BOOT_CHECKSUM_EN
                        csum_d      = csum_q + word_full;
                        if (last_word) state_d = S_CSUM;
`else
                        if (last_word) state_d = S_RUN;
`endif
                    end else begin
                        acc_d = place_byte(acc_q, byte_cnt_q, s_data);
                    end
                end
            end
`ifdef BOOT_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = (word_full == csum_q) ? S_RUN : S_ERR;
                    end else begin
                        acc_d = place_byte(acc_q, byte_cnt_q, s_data);
                    end
                end
            end
`endif
            S_RUN, S_ERR: begin
                if (load_req) begin
                    state_d    = S_HDR0;
                    n_d        = 16'd0;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = '0;
                    acc_d      = 24'd0;
`ifdef BOOT_CHECKSUM_EN
                    csum_d     = 32'd0;
`endif
                end
            end
            default: state_d = S_HDR0;
        endcase

        // Ready is registered from the next state so it never depends on s_valid.
        s_ready_d = (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_DATA);
`ifdef BOOT_CHECKSUM_EN
        if (state_d == S_CSUM) s_ready_d = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_HDR0;
            n_q         <= 16'd0;
            byte_cnt_q  <= 2'd0;
            word_cnt_q  <= '0;
            acc_q       <= 24'd0;
            s_ready_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= 32'd0;
`ifdef BOOT_CHECKSUM_EN
            csum_q      <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            byte_cnt_q  <= byte_cnt_d;
            word_cnt_q  <= word_cnt_d;
            acc_q       <= acc_d;
            s_ready_q   <= s_ready_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef BOOT_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign s_ready   = s_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;
    assign boot_done = (state_q == S_RUN);
    assign boot_err  = (state_q == S_ERR);
    assign cpu_rst   = (state_q != S_RUN);
    assign imem_addr = boot_done ? pc : 32'd0;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - self-checking bench for imem_boot_loader (table vectors plus randomized loads).
module tb_imem_boot_loader;

    localparam int MW = 1024;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_req = 1'b0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = 8'd0;
    logic          s_ready;
    logic [31:0]   pc = 32'h1234_5678;
    logic [31:0]   imem_addr;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic          cpu_rst;
    logic          boot_done;
    logic          boot_err;

    imem_boot_loader #(.MEM_WORDS(MW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .load_req(load_req), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .pc(pc), .imem_addr(imem_addr), .mem_we(mem_we),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .cpu_rst(cpu_rst),
        .boot_done(boot_done), .boot_err(boot_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;
    wr_t wlog[$];

    always @(negedge clk) begin
        if (mem_we) wlog.push_back(wr_t'{a: mem_waddr, d: mem_wdata});
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Called just after a negedge; returns at the negedge following the accepting edge.
    task automatic put(input logic [7:0] b);
        int g = 0;
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("put_ready", {31'd0, s_ready}, 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        s_valid = 1'b0;
        load_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("rst_flags", {30'd0, boot_done, boot_err}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready_after", {31'd0, s_ready}, 32'd1);
    endtask

    task automatic restart_by_req();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        chk("req_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("req_flags", {30'd0, boot_done, boot_err}, 32'd0);
        chk("req_s_ready", {31'd0, s_ready}, 32'd1);
        chk("req_imem_addr", imem_addr, 32'd0);
    endtask

    // Reference: stream = N (LE16), words LE, [checksum]; success writes word i at index i.
    task automatic do_load(input string nm, input logic [15:0] n, input logic [31:0] words[$],
                           input int gap, input bit exp_err);
        logic [7:0]  tx[$];
        logic [31:0] sum;
        sum = 32'd0;
        tx.push_back(n[7:0]);
        tx.push_back(n[15:8]);
        if (!exp_err) begin
            foreach (words[i]) begin
                for (int k = 0; k < 4; k++) tx.push_back(words[i][8*k +: 8]);
                sum += words[i];
            end
`ifdef BOOT_CHECKSUM_EN
            for (int k = 0; k < 4; k++) tx.push_back(sum[8*k +: 8]);
`endif
        end
        wlog.delete();
        foreach (tx[i]) begin
            if (gap == 1 && i > 0) @(negedge clk);
            if (gap == 2 && $urandom_range(0, 2) == 0) begin
                load_req = 1'b1;
                @(negedge clk);
                load_req = 1'b0;
            end
            put(tx[i]);
        end
        chk({nm, "_done"}, {31'd0, boot_done}, {31'd0, !exp_err});
        chk({nm, "_err"}, {31'd0, boot_err}, {31'd0, exp_err});
        chk({nm, "_cpu_rst"}, {31'd0, cpu_rst}, {31'd0, exp_err});
        chk({nm, "_s_ready"}, {31'd0, s_ready}, 32'd0);
`ifndef BOOT_CHECKSUM_EN
        chk({nm, "_last_we"}, {31'd0, mem_we}, {31'd0, (!exp_err && n != 16'd0)});
`endif
        @(negedge clk);
        chk({nm, "_nwr"}, wlog.size(), exp_err ? 32'd0 : {16'd0, n});
        for (int i = 0; i < wlog.size() && i < words.size(); i++) begin
            chk({nm, "_waddr"}, {22'd0, wlog[i].a}, i);
            chk({nm, "_wdata"}, wlog[i].d, words[i]);
        end
        pc = $urandom;
        #1;
        chk({nm, "_imem_addr"}, imem_addr, exp_err ? 32'd0 : pc);
        @(negedge clk);
    endtask

    typedef struct {
        string       nm;
        logic [15:0] n;
        logic [31:0] w0, w1, w2;
        int          gap;
        bit          err;
    } vec_t;

    vec_t        tbl[6];
    logic [31:0] wq[$];

    initial begin
        tbl[0] = '{nm: "basic", n: 16'd2,     w0: 32'h0022_8293, w1: 32'h0062_E233, w2: 32'd0, gap: 0, err: 1'b0};
        tbl[1] = '{nm: "empty", n: 16'd0,     w0: 32'd0,         w1: 32'd0,         w2: 32'd0, gap: 0, err: 1'b0};
        tbl[2] = '{nm: "over",  n: 16'h0401,  w0: 32'd0,         w1: 32'd0,         w2: 32'd0, gap: 0, err: 1'b1};
        tbl[3] = '{nm: "bp3",   n: 16'd3,     w0: 32'h1122_3344, w1: 32'h5566_7788, w2: 32'h99AA_BBCC, gap: 1, err: 1'b0};
        tbl[4] = '{nm: "cont3", n: 16'd3,     w0: 32'h1122_3344, w1: 32'h5566_7788, w2: 32'h99AA_BBCC, gap: 0, err: 1'b0};
        tbl[5] = '{nm: "one",   n: 16'd1,     w0: 32'h0000_0013, w1: 32'd0,         w2: 32'd0, gap: 0, err: 1'b0};

        reset_dut();
        chk("rst_imem_addr", imem_addr, 32'd0);
        chk("rst_waddr", {22'd0, mem_waddr}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);

        for (int t = 0; t < 6; t++) begin
            reset_dut();
            wq.delete();
            if (!tbl[t].err) begin
                if (tbl[t].n > 0) wq.push_back(tbl[t].w0);
                if (tbl[t].n > 1) wq.push_back(tbl[t].w1);
                if (tbl[t].n > 2) wq.push_back(tbl[t].w2);
            end
            do_load(tbl[t].nm, tbl[t].n, wq, tbl[t].gap, tbl[t].err);
        end

        // Oversize then restart by load_req with a single word.
        reset_dut();
        wq.delete();
        do_load("over2", 16'd1025, wq, 0, 1'b1);
        restart_by_req();
        wq.push_back(32'hCAFE_0001);
        do_load("after_err", 16'd1, wq, 0, 1'b0);

        // Reload from RUN.
        restart_by_req();
        wq.delete();
        wq.push_back(32'h0000_0013);
        do_load("reload", 16'd1, wq, 0, 1'b0);

        // Reset collides with the edge that would accept the word's 4th byte.
        reset_dut();
        put(8'h03); put(8'h00); put(8'h44); put(8'h33); put(8'h22);
        s_valid = 1'b1;
        s_data  = 8'h11;
        rst     = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        chk("midrst_we", {31'd0, mem_we}, 32'd0);
        chk("midrst_s_ready", {31'd0, s_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        wq.delete();
        wq.push_back(32'hA0A0_0000); wq.push_back(32'hB1B1_0001); wq.push_back(32'hC2C2_0002);
        do_load("after_midrst", 16'd3, wq, 0, 1'b0);

        // Full-depth load: final index MEM_WORDS-1 with no wrap.
        restart_by_req();
        wq.delete();
        for (int i = 0; i < MW; i++) wq.push_back($urandom);
        do_load("full", 16'(MW), wq, 0, 1'b0);

        // Randomized loads with idle cycles and ignored load_req pulses.
        for (int r = 0; r < 8; r++) begin
            int n;
            if (r % 2 == 0) reset_dut();
            else restart_by_req();
            n = $urandom_range(1, 8);
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back($urandom);
            do_load("rand", 16'(n), wq, 2, 1'b0);
        end

`ifdef BOOT_CHECKSUM_EN
        reset_dut();
        put(8'h02); put(8'h00);
        put(8'h93); put(8'h82); put(8'h22); put(8'h00);
        put(8'h33); put(8'hE2); put(8'h62); put(8'h00);
        put(8'hC7); put(8'h64); put(8'h85); put(8'h00);
        chk("csum_bad_err", {31'd0, boot_err}, 32'd1);
        chk("csum_bad_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        reset_dut();
        put(8'h02); put(8'h00);
        put(8'h93); put(8'h82); put(8'h22); put(8'h00);
        put(8'h33); put(8'hE2); put(8'h62); put(8'h00);
        put(8'hC6); put(8'h64); put(8'h85); put(8'h00);
        chk("csum_good_done", {31'd0, boot_done}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time controller for the single-cycle core's instruction memory. After reset it holds the CPU in reset and accepts a program as a byte stream. The stream is assembled into little-endian 32-bit words and written to consecutive instruction-memory words from index 0. Once the load completes, it releases the CPU and hands the memory read address to the PC.

## Interface
- MEM_WORDS, 1024: instruction memory depth in 32-bit words.
- ADDR_W, 10: word-index width; must equal clog2(MEM_WORDS).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- load_req  in  1  pulse; restarts a load from RUN or ERR, ignored in all other states.
- s_valid  in  1  byte-stream valid.
- s_data  in  8  byte-stream data.
- s_ready  out  1  byte-stream ready; a byte transfers when s_valid && s_ready at a rising edge.
- pc  in  32  CPU program counter.
- imem_addr  out  32  read address to instruction memory (byte address; memory indexes [31:2]).
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_waddr  out  ADDR_W  word index being written.
- mem_wdata  out  32  word being written.
- cpu_rst  out  1  active-high hold for the core.
- boot_done  out  1  high in RUN.
- boot_err  out  1  high in ERR.

## Operation
- Stream format:
  - 2-byte little-endian word count N.
  - Then 4·N bytes, each word least-significant byte first.
  - Then, with BOOT_CHECKSUM_EN only, 4 checksum bytes.
- States and transitions:
  - HDR0: capture N[7:0] on handshake → HDR1.
  - HDR1: capture N[15:8] on handshake, then:
    - N == 0 → RUN.
    - N > MEM_WORDS → ERR.
    - otherwise → DATA.
  - DATA: a 2-bit byte counter places each byte at bits [8k+7:8k].
    - On the 4th byte, register the word, its index and mem_we = 1.
    - Word index counter increments after each write.
    - After word N−1 → RUN, or → CSUM with the macro defined.
  - CSUM: collect 4 bytes → RUN if the value equals the checksum, else → ERR.
  - RUN: cpu_rst = 0, boot_done = 1, imem_addr = pc, s_ready = 0.
  - ERR: cpu_rst = 1, boot_err = 1, s_ready = 0, no writes.
- Signal behaviour:
  - s_ready = 1 exactly in HDR0, HDR1, DATA and CSUM. It is decoded from registered state; no combinational path from s_valid.
  - imem_addr = 0 in every state except RUN.
  - cpu_rst = 1 in every state except RUN.
- Arithmetic and sizing:
  - N is 16 bits.
  - The word counter holds 0..MEM_WORDS−1; N == MEM_WORDS fills the memory with no wrap.
  - The checksum is the 32-bit sum of all data words, modulo 2^32.
- load_req in RUN or ERR:
  - Next cycle: HDR0, cpu_rst = 1, boot_done = 0, boot_err = 0.
  - Byte and word counters and the accumulator clear.
  - Previously written memory contents are not erased.
- load_req in HDR0/HDR1/DATA/CSUM: no effect.
- rst mid-load: next cycle HDR0, counters cleared, any pending mem_we dropped.

## Timing
- Reset values, all registered:
  - s_ready = 0 while rst is high, 1 in the first cycle after rst falls.
  - mem_we = 0, mem_waddr = 0, mem_wdata = 0.
  - cpu_rst = 1, boot_done = 0, boot_err = 0, imem_addr = 0.
- Word write latency: mem_we is high for exactly the one cycle after the edge that accepts the word's 4th byte.
- Back-to-back streaming: 1 byte per cycle, hence one write every 4 cycles; gaps in s_valid stall the counters only.
- Release:
  - The state becomes RUN on the edge that issues the last mem_we (or on the last CSUM byte / HDR1 byte for N = 0).
  - cpu_rst falls in that same cycle.
  - The last write is visible to memory at the same edge the core leaves reset.

## Configuration
- BOOT_CHECKSUM_EN defined:
  - CSUM state and 32-bit accumulator are present.
  - A mismatch goes to ERR.
  - With N = 0 the load still expects 4 checksum bytes, which must be 0x00000000.
- Undefined: no CSUM state, no accumulator; DATA → RUN after the last word.

## Test plan
- Basic load:
  - Stimulus: bytes 02 00 93 82 22 00 33 E2 62 00, continuous.
  - Expected: mem_we twice, waddr 0 data 0x00228293 then waddr 1 data 0x0062E233.
  - Expected: cpu_rst falls in the cycle of the 2nd write; then imem_addr tracks pc.
- Empty program: bytes 00 00 → RUN one cycle after the 2nd byte, no mem_we.
- Oversize: bytes 01 04 (N = 1025) → ERR, boot_err = 1, s_ready = 0, no writes.
  - Then load_req with N = 1 → RUN, boot_err = 0.
- Backpressure and reset:
  - Stimulus: s_valid toggling 1-0-1 across a 3-word load.
  - Expected: words and indices are identical to the continuous case.
  - Stimulus: rst pulsed after 6 bytes.
  - Expected: the restarted load writes from index 0.
- Reload: in RUN, pulse load_req and send 01 00 13 00 00 00.
  - Expected: cpu_rst = 1 during the load, one write of waddr 0 data 0x00000013, RUN again.
- BOOT_CHECKSUM_EN: the basic load plus checksum bytes C6 64 85 00 → RUN.
  - Same load with checksum bytes C7 64 85 00 → ERR.
